mant_div_seq: RTL and testbench



---
 rtl/mant_div_seq.sv | 133 +++++++++++++
 tb/tb_mant_div_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mant_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mant_div_seq
//  Description : Iterative unsigned restoring divider for FPU mantissas.
//                Produces one quotient bit per clock: DWIDTH integer bits
//                followed by FBITS fraction bits, plus remainder and sticky.
//  Revision    : 1.0 - initial release
// ============================================================================
module mant_div_seq #(
    parameter int DWIDTH = 24,
    parameter int FBITS  = 2,
    parameter int CWIDTH = $clog2(DWIDTH + FBITS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DWIDTH-1:0]          dividend,
    input  logic [DWIDTH-1:0]          divisor,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DWIDTH+FBITS-1:0]    quotient,
    output logic [DWIDTH-1:0]          remainder,
    output logic                       sticky,
    output logic                       div_by_zero
);

    localparam int QW = DWIDTH + FBITS;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]        r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [QW-1:0]     r_num;        // numerator bits still to be consumed, MSB first
    logic [DWIDTH-1:0] r_divisor;
    logic [DWIDTH-1:0] r_rem;        // partial remainder, always < divisor
    logic [QW-1:0]     r_quot;
    logic [CWIDTH-1:0] r_cnt;
    logic [DWIDTH-1:0] r_remainder;
    logic              r_sticky;
    logic              r_dbz;

    logic [DWIDTH:0]   w_shift;
    logic              w_ge;
    logic [DWIDTH:0]   w_next_rem;
    logic              w_last;

    // One restoring step: bring in the next numerator bit, subtract if it fits
    always_comb begin
        w_shift    = {r_rem, r_num[QW-1]};
        w_ge       = (w_shift >= {1'b0, r_divisor});
        w_next_rem = w_ge ? (w_shift - {1'b0, r_divisor}) : w_shift;
        w_last     = (r_cnt == CWIDTH'(1));
    end

    // Control FSM and datapath registers; all outputs are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_num       <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_cnt       <= '0;
            r_remainder <= '0;
            r_sticky    <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_divisor  <= divisor;
                        r_num      <= QW'(dividend) << FBITS;
                        r_rem      <= '0;
                        r_in_ready <= 1'b0;
                        if (divisor == '0) begin
                            // Nothing to iterate: report saturated quotient at once
                            r_state     <= c_ST_DONE;
                            r_out_valid <= 1'b1;
                            r_dbz       <= 1'b1;
                            r_quot      <= '1;
                            r_remainder <= '0;
                            r_sticky    <= 1'b0;
                        end else begin
                            r_state <= c_ST_CALC;
                            r_dbz   <= 1'b0;
                            r_quot  <= '0;
                            r_cnt   <= CWIDTH'(QW);
                        end
                    end
                end
                c_ST_CALC: begin
                    r_rem  <= w_next_rem[DWIDTH-1:0];
                    r_quot <= {r_quot[QW-2:0], w_ge};
                    r_num  <= r_num << 1;
                    r_cnt  <= r_cnt - CWIDTH'(1);
                    if (w_last) begin
                        r_state     <= c_ST_DONE;
                        r_out_valid <= 1'b1;
                        r_remainder <= w_next_rem[DWIDTH-1:0];
                        r_sticky    <= |w_next_rem;
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= c_ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quot;
    assign remainder   = r_remainder;
    assign sticky      = r_sticky;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_mant_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mant_div_seq
//  Description : Directed self-checking bench for mant_div_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mant_div_seq;

    localparam int c_DW = 24;
    localparam int c_FB = 2;
    localparam int c_QW = c_DW + c_FB;

    logic              r_clk = 1'b0;
    logic              r_rst = 1'b1;
    logic              r_in_valid = 1'b0;
    logic              r_out_ready = 1'b0;
    logic [c_DW-1:0]   r_dividend = '0;
    logic [c_DW-1:0]   r_divisor = '0;
    logic              w_in_ready;
    logic              w_out_valid;
    logic [c_QW-1:0]   w_quotient;
    logic [c_DW-1:0]   w_remainder;
    logic              w_sticky;
    logic              w_dbz;

    int n_vec = 0;
    int n_err = 0;
    int lat;
    int calc_busy;

    mant_div_seq #(.DWIDTH(c_DW), .FBITS(c_FB)) dut (
        .clk         (r_clk),
        .rst         (r_rst),
        .in_valid    (r_in_valid),
        .in_ready    (w_in_ready),
        .dividend    (r_dividend),
        .divisor     (r_divisor),
        .out_valid   (w_out_valid),
        .out_ready   (r_out_ready),
        .quotient    (w_quotient),
        .remainder   (w_remainder),
        .sticky      (w_sticky),
        .div_by_zero (w_dbz)
    );

    always #5 r_clk = ~r_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    // Present operands for one accepted edge; returns 1 after that edge
    task automatic accept(input logic [c_DW-1:0] dvd, input logic [c_DW-1:0] dvs);
        int guard;
        guard = 0;
        while (!w_in_ready && guard < 100) begin
            tick();
            guard++;
        end
        chk("in_ready_timeout", 64'(w_in_ready), 64'd1);
        r_dividend = dvd;
        r_divisor  = dvs;
        r_in_valid = 1'b1;
        tick();
        r_in_valid = 1'b0;
    endtask

    // Count edges after the acceptance edge until out_valid is seen;
    // also count how many of those cycles showed in_ready low
    task automatic wait_out(output int edges, output int busy);
        edges = 0;
        busy  = 0;
        while (!w_out_valid && edges < 200) begin
            if (!w_in_ready) busy++;
            tick();
            edges++;
        end
        chk("out_valid_timeout", 64'(w_out_valid), 64'd1);
    endtask

    task automatic consume();
        r_out_ready = 1'b1;
        tick();
        r_out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        r_rst = 1'b0;
        chk("rst_in_ready",  64'(w_in_ready),  64'd1);
        chk("rst_out_valid", 64'(w_out_valid), 64'd0);
        chk("rst_quotient",  64'(w_quotient),  64'd0);
        chk("rst_remainder", 64'(w_remainder), 64'd0);
        chk("rst_sticky",    64'(w_sticky),    64'd0);
        chk("rst_dbz",       64'(w_dbz),       64'd0);

        // 1.0 / 1.0 : 2^25 / 2^23 = 4 exactly, 26 edges after acceptance
        accept(24'h800000, 24'h800000);
        wait_out(lat, calc_busy);
        chk("t1_latency",   64'(lat),         64'd26);
        chk("t1_busy",      64'(calc_busy),   64'd26);
        chk("t1_quotient",  64'(w_quotient),  64'd4);
        chk("t1_remainder", 64'(w_remainder), 64'd0);
        chk("t1_sticky",    64'(w_sticky),    64'd0);
        chk("t1_dbz",       64'(w_dbz),       64'd0);
        chk("t1_in_ready",  64'(w_in_ready),  64'd0);
        consume();
        chk("t1_out_valid_after", 64'(w_out_valid), 64'd0);
        chk("t1_in_ready_after",  64'(w_in_ready),  64'd1);

        // Max/1.0 with out_ready already high: (2^26-4)/2^23 = 7 r 0x7FFFFC
        r_out_ready = 1'b1;
        accept(24'hFFFFFF, 24'h800000);
        wait_out(lat, calc_busy);
        chk("t2_quotient",  64'(w_quotient),  64'd7);
        chk("t2_remainder", 64'(w_remainder), 64'h7FFFFC);
        chk("t2_sticky",    64'(w_sticky),    64'd1);
        tick();
        r_out_ready = 1'b0;
        chk("t2_consumed_first_done", 64'(w_out_valid), 64'd0);

        // Divide by zero: result visible right after the acceptance edge
        accept(24'h123456, 24'h000000);
        wait_out(lat, calc_busy);
        chk("t4_latency",   64'(lat),         64'd0);
        chk("t4_dbz",       64'(w_dbz),       64'd1);
        chk("t4_quotient",  64'(w_quotient),  64'h3FFFFFF);
        chk("t4_remainder", 64'(w_remainder), 64'd0);
        chk("t4_sticky",    64'(w_sticky),    64'd0);
        consume();

        // 40 / 3 = 13 r 1; also div_by_zero must clear on this acceptance
        accept(24'd10, 24'd3);
        chk("t3_dbz_cleared", 64'(w_dbz), 64'd0);
        wait_out(lat, calc_busy);
        chk("t3_latency",   64'(lat),         64'd26);
        chk("t3_quotient",  64'(w_quotient),  64'd13);
        chk("t3_remainder", 64'(w_remainder), 64'd1);
        chk("t3_sticky",    64'(w_sticky),    64'd1);
        consume();

        // Backpressure: 100/7 -> 400/7 = 57 r 1; new operands pulsed while busy
        accept(24'd100, 24'd7);
        wait_out(lat, calc_busy);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                r_dividend = 24'd9;
                r_divisor  = 24'd2;
                r_in_valid = 1'b1;
            end
            tick();
            r_in_valid = 1'b0;
        end
        chk("t5_out_valid_held", 64'(w_out_valid), 64'd1);
        chk("t5_in_ready_low",   64'(w_in_ready),  64'd0);
        chk("t5_quotient_held",  64'(w_quotient),  64'd57);
        chk("t5_remainder_held", 64'(w_remainder), 64'd1);
        chk("t5_sticky_held",    64'(w_sticky),    64'd1);
        consume();
        chk("t5_in_ready_back", 64'(w_in_ready),  64'd1);
        tick();
        tick();
        chk("t5_no_ghost_op",   64'(w_out_valid), 64'd0);
        chk("t5_still_idle",    64'(w_in_ready),  64'd1);

        // Reset during the 10th CALC cycle, then a clean 10/3
        accept(24'hABCDEF, 24'd5);
        for (int i = 0; i < 9; i++) tick();
        chk("t6_mid_calc", 64'(w_out_valid), 64'd0);
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
        chk("t6_in_ready",  64'(w_in_ready),  64'd1);
        chk("t6_out_valid", 64'(w_out_valid), 64'd0);
        chk("t6_quotient",  64'(w_quotient),  64'd0);
        chk("t6_remainder", 64'(w_remainder), 64'd0);
        chk("t6_sticky",    64'(w_sticky),    64'd0);
        chk("t6_dbz",       64'(w_dbz),       64'd0);
        accept(24'd10, 24'd3);
        wait_out(lat, calc_busy);
        chk("t6_post_latency",   64'(lat),         64'd26);
        chk("t6_post_quotient",  64'(w_quotient),  64'd13);
        chk("t6_post_remainder", 64'(w_remainder), 64'd1);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
